// File: rtl/mdr_unit_if.sv
// Bundle of the MDR stage data/control signals: source select, load enable,
// both data sources, the mux output and the register contents.
interface mdr_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             mdrin;
  logic             read;
  logic [WIDTH-1:0] bmi;
  logic [WIDTH-1:0] mdi;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;

  modport master (
    output mdrin, read, bmi, mdi,
    input  D, Q
  );

  modport slave (
    input  mdrin, read, bmi, mdi,
    output D, Q
  );
endinterface

// File: rtl/mdr_unit.sv
// Memory Data Register stage: MuxMD picks bus or memory data, and the MDR
// captures it on load-enabled rising edges; clr is synchronous and wins.
module mdr_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      clr,
  mdr_unit_if.slave bus
);

  logic [WIDTH-1:0] mux_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Ternary rather than if/else so an unknown select propagates instead of
  // silently falling back to the bus source.
  always_comb begin
    mux_d = bus.read ? bus.mdi : bus.bmi;
  end

  always_comb begin
    q_d = q_q;
    if (bus.mdrin) begin
      q_d = mux_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.D = mux_d;
  assign bus.Q = q_q;

endmodule

// File: tb/tb_mdr_unit.sv
// Directed and randomized checks of the MDR stage: mux output, load, hold,
// clear priority and synchronous-only clear, with expected Q values queued.
module tb_mdr_unit;
  localparam int unsigned W = 32;

  logic clk;
  logic clr;
  int   checks;
  int   passed;
  logic [W-1:0] sb[$];
  logic [W-1:0] model_q;
  logic [W-1:0] rb;
  logic [W-1:0] rm;
  logic         rclr;
  logic         rld;
  logic         rsel;

  mdr_unit_if #(.WIDTH(W)) bus_if ();

  mdr_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_q(input string tag);
    logic [W-1:0] e;
    if (sb.size() == 0) begin
      checks++;
      $error("FAIL %s: observed %h expected scoreboard entry, queue empty", tag, bus_if.Q);
    end else begin
      e = sb.pop_front();
      check(tag, bus_if.Q, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    clr = 1'b1;
    bus_if.mdrin = 1'b0;
    bus_if.read  = 1'b0;
    bus_if.bmi   = 32'd2;
    bus_if.mdi   = 32'd3;

    // Clear from power-up
    sb.push_back('0);
    tick();
    check_q("reset_q");

    // Mux select, no edge in between
    bus_if.read = 1'b1;
    #1;
    check("mux_read1", bus_if.D, 32'd3);
    bus_if.read = 1'b0;
    #1;
    check("mux_read0", bus_if.D, 32'd2);

    // Load from memory, then from bus
    clr = 1'b0;
    bus_if.mdrin = 1'b1;
    bus_if.read  = 1'b1;
    sb.push_back(32'd3);
    tick();
    check_q("load_mem");

    bus_if.read = 1'b0;
    sb.push_back(32'd2);
    tick();
    check_q("load_bus");

    bus_if.read = 1'b1;
    sb.push_back(32'd3);
    tick();
    check_q("reload_mem");

    // Hold with toggling select
    bus_if.mdrin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_if.read = ~bus_if.read;
      #1;
      check("hold_d", bus_if.D, bus_if.read ? 32'd3 : 32'd2);
      sb.push_back(32'd3);
      tick();
      check_q("hold_q");
    end

    // Clear beats load at the same edge, and keeps Q at zero
    bus_if.read  = 1'b1;
    bus_if.mdrin = 1'b1;
    clr = 1'b1;
    sb.push_back('0);
    tick();
    check_q("clr_prio");
    for (int i = 0; i < 3; i++) begin
      sb.push_back('0);
      tick();
      check_q("clr_held");
    end
    clr = 1'b0;
    sb.push_back(32'd3);
    tick();
    check_q("clr_release_load");

    // Clear pulse entirely between edges does nothing
    bus_if.mdrin = 1'b0;
    clr = 1'b1;
    #3;
    clr = 1'b0;
    sb.push_back(32'd3);
    tick();
    check_q("clr_glitch");

    // Clear asserted across an edge takes effect only at that edge
    clr = 1'b1;
    #2;
    check("clr_before_edge", bus_if.Q, 32'd3);
    sb.push_back('0);
    tick();
    check_q("clr_at_edge");
    clr = 1'b0;

    // Only the values present at the edge are captured
    bus_if.mdrin = 1'b1;
    bus_if.read  = 1'b0;
    bus_if.bmi   = 32'hDEAD_BEEF;
    #3;
    bus_if.bmi   = 32'h1234_5678;
    sb.push_back(32'h1234_5678);
    tick();
    check_q("late_change");
    bus_if.mdrin = 1'b0;
    bus_if.bmi   = 32'hFFFF_FFFF;
    #3;
    bus_if.mdrin = 1'b1;
    bus_if.bmi   = 32'hFFFF_FFFF;
    sb.push_back(32'hFFFF_FFFF);
    tick();
    check_q("all_ones");

    // Randomized mix against a reference model
    model_q = 32'hFFFF_FFFF;
    for (int i = 0; i < 24; i++) begin
      rb   = $urandom;
      rm   = $urandom;
      rclr = ($urandom_range(0, 3) == 0);
      rld  = $urandom_range(0, 1) == 1;
      rsel = $urandom_range(0, 1) == 1;
      clr          = rclr;
      bus_if.mdrin = rld;
      bus_if.read  = rsel;
      bus_if.bmi   = rb;
      bus_if.mdi   = rm;
      #1;
      check("rand_d", bus_if.D, rsel ? rm : rb);
      if (rclr) model_q = '0;
      else if (rld) model_q = rsel ? rm : rb;
      sb.push_back(model_q);
      tick();
      check_q("rand_q");
    end

    if (sb.size() != 0) begin
      checks++;
      $error("FAIL sb_drain: observed %0d leftover entries expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
